// File: rtl/instr_pipe_pkg.sv
// ============================================================================
// Module  : instr_pipe_pkg
// Purpose : Shared definitions for the instruction pipeline and hazard unit:
//           opcode/funct encodings, forwarding-select encodings, the decoded
//           instruction kind and the parse_instr field decoder.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_pipe_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
  localparam logic [5:0] c_OP_J       = 6'b000010;
  localparam logic [5:0] c_OP_JAL     = 6'b000011;
  localparam logic [5:0] c_OP_BEQ     = 6'b000100;
  localparam logic [5:0] c_OP_ADDI    = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU   = 6'b001001;
  localparam logic [5:0] c_OP_ANDI    = 6'b001100;
  localparam logic [5:0] c_OP_ORI     = 6'b001101;
  localparam logic [5:0] c_OP_LUI     = 6'b001111;
  localparam logic [5:0] c_OP_LW      = 6'b100011;
  localparam logic [5:0] c_OP_SW      = 6'b101011;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] c_FN_SLL  = 6'b000000;
  localparam logic [5:0] c_FN_JR   = 6'b001000;
  localparam logic [5:0] c_FN_ADDU = 6'b100001;
  localparam logic [5:0] c_FN_SUBU = 6'b100011;
  localparam logic [5:0] c_FN_XOR  = 6'b100110;
  localparam logic [5:0] c_FN_SLT  = 6'b101010;

  // Forwarding-select encodings
  localparam logic [1:0] c_FWD_RF  = 2'b00;  // register file / pipe value
  localparam logic [1:0] c_FWD_MEM = 2'b01;  // EX/MEM result
  localparam logic [1:0] c_FWD_WB  = 2'b10;  // MEM/WB result

  localparam logic [4:0] c_REG_RA = 5'd31;

  typedef enum logic [4:0] {
    K_NOP, K_ADDU, K_SUBU, K_SLT, K_SLL, K_XOR, K_JR,
    K_ORI, K_LUI, K_ADDI, K_ADDIU, K_ANDI, K_LW, K_SW,
    K_BEQ, K_J, K_JAL
  } instr_kind_e;

  typedef struct packed {
    instr_kind_e kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } instr_fields_t;

  // Field decoder; anything outside the supported set decodes as K_NOP.
  function automatic instr_fields_t parse_instr(input logic [31:0] instr);
    instr_fields_t f;
    f.rs   = instr[25:21];
    f.rt   = instr[20:16];
    f.rd   = instr[15:11];
    f.kind = K_NOP;
    case (instr[31:26])
      c_OP_SPECIAL: begin
        case (instr[5:0])
          c_FN_ADDU: f.kind = K_ADDU;
          c_FN_SUBU: f.kind = K_SUBU;
          c_FN_SLT:  f.kind = K_SLT;
          c_FN_SLL:  f.kind = K_SLL;
          c_FN_XOR:  f.kind = K_XOR;
          c_FN_JR:   f.kind = K_JR;
          default:   f.kind = K_NOP;
        endcase
      end
      c_OP_ORI:   f.kind = K_ORI;
      c_OP_LUI:   f.kind = K_LUI;
      c_OP_ADDI:  f.kind = K_ADDI;
      c_OP_ADDIU: f.kind = K_ADDIU;
      c_OP_ANDI:  f.kind = K_ANDI;
      c_OP_LW:    f.kind = K_LW;
      c_OP_SW:    f.kind = K_SW;
      c_OP_BEQ:   f.kind = K_BEQ;
      c_OP_J:     f.kind = K_J;
      c_OP_JAL:   f.kind = K_JAL;
      default:    f.kind = K_NOP;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_pipe_instr_class.sv
// ============================================================================
// Module  : instr_class
// Purpose : Classifies one instruction word for the hazard unit.
// Ports   : instr   in  32  instruction word
//           dest    out 5   destination register (0 = none)
//           use_rs  out 1   rs is a source operand
//           use_rt  out 1   rt is a source operand
//           tuse_rs out 2   cycles from ID until rs is needed
//           tuse_rt out 2   cycles from ID until rt is needed
//           tnew_e  out 2   cycles until the result exists, seen from EX
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_class
  import instr_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  dest,
  output logic        use_rs,
  output logic        use_rt,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew_e
);

  instr_fields_t w_f;

  always_comb begin
    w_f     = parse_instr(instr);
    dest    = 5'd0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    tuse_rs = 2'd0;
    tuse_rt = 2'd0;
    tnew_e  = 2'd0;
    case (w_f.kind)
      K_ADDU, K_SUBU, K_SLT, K_XOR: begin
        dest = w_f.rd; use_rs = 1'b1; use_rt = 1'b1;
        tuse_rs = 2'd1; tuse_rt = 2'd1; tnew_e = 2'd1;
      end
      // sll shifts rt; its rs field is unused
      K_SLL: begin
        dest = w_f.rd; use_rt = 1'b1; tuse_rt = 2'd1; tnew_e = 2'd1;
      end
      K_ORI, K_ADDI, K_ADDIU, K_ANDI: begin
        dest = w_f.rt; use_rs = 1'b1; tuse_rs = 2'd1; tnew_e = 2'd1;
      end
      K_LUI: begin
        dest = w_f.rt; tnew_e = 2'd1;
      end
      K_LW: begin
        dest = w_f.rt; use_rs = 1'b1; tuse_rs = 2'd1; tnew_e = 2'd2;
      end
      // store data is only needed in MEM, hence Tuse 2 on rt
      K_SW: begin
        use_rs = 1'b1; use_rt = 1'b1; tuse_rs = 2'd1; tuse_rt = 2'd2;
      end
      K_BEQ: begin
        use_rs = 1'b1; use_rt = 1'b1;
      end
      K_JR: begin
        use_rs = 1'b1;
      end
      K_JAL: begin
        dest = c_REG_RA; tnew_e = 2'd1;
      end
      default: begin
        dest = 5'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_pipe.sv
// ============================================================================
// Module  : instr_pipe
// Purpose : IF/ID, ID/EX, EX/MEM, MEM/WB instruction/PC register chain with
//           Tuse/Tnew hazard detection (stall + bubble) and forwarding selects.
// Ports   : clk, rst_n (async active-low)
//           instr_f, pc_f              fetched word and its PC
//           instr_d/e/m/w, pc_d/e/m/w  per-stage instruction and PC
//           stall, pc_en               hazard stall and PC write enable
//           fwd_rs_d, fwd_rt_d         ID compare operand selects
//           fwd_rs_e, fwd_rt_e         EX operand selects
//           fwd_rt_m                   sw store-data select
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_pipe
  import instr_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] instr_e,
  output logic [31:0] instr_m,
  output logic [31:0] instr_w,
  output logic [31:0] pc_d,
  output logic [31:0] pc_e,
  output logic [31:0] pc_m,
  output logic [31:0] pc_w,
  output logic        stall,
  output logic        pc_en,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
);

  logic [31:0] r_instr_d, r_instr_e, r_instr_m, r_instr_w;
  logic [31:0] r_pc_d, r_pc_e, r_pc_m, r_pc_w;

  logic [4:0] w_dest_d, w_dest_e, w_dest_m, w_dest_w;
  logic       w_use_rs_d, w_use_rt_d, w_use_rs_e, w_use_rt_e;
  logic       w_use_rs_m, w_use_rt_m, w_use_rs_w, w_use_rt_w;
  logic [1:0] w_tuse_rs_d, w_tuse_rt_d, w_tuse_rs_e, w_tuse_rt_e;
  logic [1:0] w_tuse_rs_m, w_tuse_rt_m, w_tuse_rs_w, w_tuse_rt_w;
  logic [1:0] w_tnew_d, w_tnew_e, w_tnew_em, w_tnew_ew, w_tnew_m;

  instr_class u_class_d (.instr(r_instr_d), .dest(w_dest_d), .use_rs(w_use_rs_d),
    .use_rt(w_use_rt_d), .tuse_rs(w_tuse_rs_d), .tuse_rt(w_tuse_rt_d), .tnew_e(w_tnew_d));
  instr_class u_class_e (.instr(r_instr_e), .dest(w_dest_e), .use_rs(w_use_rs_e),
    .use_rt(w_use_rt_e), .tuse_rs(w_tuse_rs_e), .tuse_rt(w_tuse_rt_e), .tnew_e(w_tnew_e));
  instr_class u_class_m (.instr(r_instr_m), .dest(w_dest_m), .use_rs(w_use_rs_m),
    .use_rt(w_use_rt_m), .tuse_rs(w_tuse_rs_m), .tuse_rt(w_tuse_rt_m), .tnew_e(w_tnew_em));
  instr_class u_class_w (.instr(r_instr_w), .dest(w_dest_w), .use_rs(w_use_rs_w),
    .use_rt(w_use_rt_w), .tuse_rs(w_tuse_rs_w), .tuse_rt(w_tuse_rt_w), .tnew_e(w_tnew_ew));

  // Classifier outputs that no stage consumes are collected here.
  logic w_unused;
  assign w_unused = ^{w_dest_d, w_tnew_d, w_use_rs_e, w_use_rt_e, w_tuse_rs_e,
                      w_tuse_rt_e, w_use_rs_m, w_use_rt_m, w_tuse_rs_m, w_tuse_rt_m,
                      w_use_rs_w, w_use_rt_w, w_tuse_rs_w, w_tuse_rt_w, w_tnew_ew};

  // One cycle later the producer is one cycle closer to having its result.
  assign w_tnew_m = (w_tnew_em == 2'd0) ? 2'd0 : w_tnew_em - 2'd1;

  logic [4:0] w_rs_d, w_rt_d, w_rs_e, w_rt_e, w_rt_m;
  assign w_rs_d = r_instr_d[25:21];
  assign w_rt_d = r_instr_d[20:16];
  assign w_rs_e = r_instr_e[25:21];
  assign w_rt_e = r_instr_e[20:16];
  assign w_rt_m = r_instr_m[20:16];

  // A source hazards when a pending producer will not have its result by
  // the time this operand is consumed.
  function automatic logic hazard(input logic used, input logic [4:0] src,
                                  input logic [1:0] tuse);
    return used && (src != 5'd0) &&
           (((src == w_dest_e) && (w_tnew_e > tuse)) ||
            ((src == w_dest_m) && (w_tnew_m > tuse)));
  endfunction

  // Only a finished result can be forwarded; MEM is checked first so the
  // youngest producer wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if ((src != 5'd0) && (src == w_dest_m) && (w_tnew_m == 2'd0))
      return c_FWD_MEM;
    else if ((src != 5'd0) && (src == w_dest_w))
      return c_FWD_WB;
    else
      return c_FWD_RF;
  endfunction

  logic w_stall;
  assign w_stall = hazard(w_use_rs_d, w_rs_d, w_tuse_rs_d) |
                   hazard(w_use_rt_d, w_rt_d, w_tuse_rt_d);

  assign stall    = w_stall;
  assign pc_en    = ~w_stall;
  assign fwd_rs_d = fwd_sel(w_rs_d);
  assign fwd_rt_d = fwd_sel(w_rt_d);
  assign fwd_rs_e = fwd_sel(w_rs_e);
  assign fwd_rt_e = fwd_sel(w_rt_e);
  assign fwd_rt_m = (r_instr_m[31:26] == c_OP_SW) && (w_rt_m != 5'd0) &&
                    (w_rt_m == w_dest_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d <= '0; r_pc_d <= '0;
      r_instr_e <= '0; r_pc_e <= '0;
      r_instr_m <= '0; r_pc_m <= '0;
      r_instr_w <= '0; r_pc_w <= '0;
    end else begin
      if (!w_stall) begin
        r_instr_d <= instr_f;
        r_pc_d    <= pc_f;
        r_instr_e <= r_instr_d;
        r_pc_e    <= r_pc_d;
      end else begin
        // IF/ID holds, EX receives a bubble
        r_instr_e <= '0;
        r_pc_e    <= '0;
      end
      r_instr_m <= r_instr_e;
      r_pc_m    <= r_pc_e;
      r_instr_w <= r_instr_m;
      r_pc_w    <= r_pc_m;
    end
  end

  assign instr_d = r_instr_d;
  assign instr_e = r_instr_e;
  assign instr_m = r_instr_m;
  assign instr_w = r_instr_w;
  assign pc_d    = r_pc_d;
  assign pc_e    = r_pc_e;
  assign pc_m    = r_pc_m;
  assign pc_w    = r_pc_w;

endmodule

`default_nettype wire

// File: tb/tb_instr_pipe.sv
// ============================================================================
// Module  : tb_instr_pipe
// Purpose : Directed self-checking bench for instr_pipe.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_pipe;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_f, pc_f;
  logic [31:0] instr_d, instr_e, instr_m, instr_w;
  logic [31:0] pc_d, pc_e, pc_m, pc_w;
  logic        stall, pc_en, fwd_rt_m;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int passed = 0;
  int total  = 0;

  instr_pipe dut (
    .clk(clk), .rst_n(rst_n), .instr_f(instr_f), .pc_f(pc_f),
    .instr_d(instr_d), .instr_e(instr_e), .instr_m(instr_m), .instr_w(instr_w),
    .pc_d(pc_d), .pc_e(pc_e), .pc_m(pc_m), .pc_w(pc_w),
    .stall(stall), .pc_en(pc_en),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                        input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a fetch word, then wait through the next rising edge.
  task automatic step(input logic [31:0] i, input logic [31:0] p);
    instr_f = i;
    pc_f    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) step(32'h0, 32'h0);
  endtask

  logic [31:0] lw1, addu1, addu_a, beq1, jr1, sw1, addu_z0, addu_z1;

  initial begin
    lw1     = itype(6'b100011, 2, 1, 0);        // lw   $1,0($2)
    addu1   = rtype(1, 4, 3, 6'b100001);        // addu $3,$1,$4
    addu_a  = rtype(2, 3, 1, 6'b100001);        // addu $1,$2,$3
    beq1    = itype(6'b000100, 1, 4, 3);        // beq  $1,$4,3
    jr1     = rtype(1, 0, 0, 6'b001000);        // jr   $1
    sw1     = itype(6'b101011, 3, 1, 4);        // sw   $1,4($3)
    addu_z0 = rtype(2, 3, 0, 6'b100001);        // addu $0,$2,$3
    addu_z1 = rtype(0, 0, 4, 6'b100001);        // addu $4,$0,$0

    rst_n   = 1'b0;
    instr_f = 32'h0;
    pc_f    = 32'h0;
    step(lw1, 32'h40);
    step(lw1, 32'h44);
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
    rst_n = 1'b1;

    // Load-use to an EX consumer
    step(lw1, 32'h100);
    chk("lu_instr_d", instr_d, lw1);
    chk("lu_pc_d", pc_d, 32'h100);
    step(addu1, 32'h104);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    step(32'h0, 32'h108);
    chk("lu_bubble", instr_e, 32'h0);
    chk("lu_hold_d", instr_d, addu1);
    chk("lu_stall_end", {31'd0, stall}, 32'd0);
    chk("lu_lw_m", instr_m, lw1);
    step(32'h0, 32'h10c);
    chk("lu_addu_e", instr_e, addu1);
    chk("lu_pc_e", pc_e, 32'h104);
    chk("lu_fwd_rs_e", {30'd0, fwd_rs_e}, 32'd2);
    chk("lu_fwd_rt_e", {30'd0, fwd_rt_e}, 32'd0);
    chk("lu_pc_w", pc_w, 32'h100);
    flush();

    // ALU result to beq
    step(addu_a, 32'h200);
    step(beq1, 32'h204);
    chk("ab_stall", {31'd0, stall}, 32'd1);
    step(32'h0, 32'h208);
    chk("ab_stall_end", {31'd0, stall}, 32'd0);
    chk("ab_addu_m", instr_m, addu_a);
    chk("ab_fwd_rs_d", {30'd0, fwd_rs_d}, 32'd1);
    chk("ab_fwd_rt_d", {30'd0, fwd_rt_d}, 32'd0);
    flush();

    // lw to jr: two stall cycles
    step(lw1, 32'h300);
    step(jr1, 32'h304);
    chk("lj_stall1", {31'd0, stall}, 32'd1);
    step(32'h0, 32'h308);
    chk("lj_stall2", {31'd0, stall}, 32'd1);
    chk("lj_hold_d", instr_d, jr1);
    step(32'h0, 32'h308);
    chk("lj_stall_end", {31'd0, stall}, 32'd0);
    chk("lj_fwd_rs_d", {30'd0, fwd_rs_d}, 32'd2);
    flush();

    // lw to sw data: no stall, store data forwarded in MEM
    step(lw1, 32'h400);
    step(sw1, 32'h404);
    chk("ls_stall_d", {31'd0, stall}, 32'd0);
    step(32'h0, 32'h408);
    chk("ls_stall_e", {31'd0, stall}, 32'd0);
    chk("ls_fwd_rt_e", {30'd0, fwd_rt_e}, 32'd0);
    chk("ls_fwd_rt_m_early", {31'd0, fwd_rt_m}, 32'd0);
    step(32'h0, 32'h40c);
    chk("ls_sw_m", instr_m, sw1);
    chk("ls_fwd_rt_m", {31'd0, fwd_rt_m}, 32'd1);
    flush();

    // $0 destination never hazards or forwards
    step(addu_z0, 32'h500);
    step(addu_z1, 32'h504);
    chk("z_stall", {31'd0, stall}, 32'd0);
    chk("z_fwd_d", {28'd0, fwd_rs_d, fwd_rt_d}, 32'd0);
    step(32'h0, 32'h508);
    chk("z_fwd_e", {28'd0, fwd_rs_e, fwd_rt_e}, 32'd0);
    step(32'h0, 32'h50c);
    chk("z_fwd_rt_m", {31'd0, fwd_rt_m}, 32'd0);
    flush();

    // Asynchronous reset in the middle of a stall with lw in EX
    step(lw1, 32'h600);
    step(jr1, 32'h604);
    chk("ar_lw_e", instr_e, lw1);
    chk("ar_pre_stall", {31'd0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_instr_d", instr_d, 32'h0);
    chk("ar_instr_e", instr_e, 32'h0);
    chk("ar_instrs_mw", instr_m | instr_w, 32'h0);
    chk("ar_pcs", pc_d | pc_e | pc_m | pc_w, 32'h0);
    chk("ar_stall", {31'd0, stall}, 32'd0);
    chk("ar_pc_en", {31'd0, pc_en}, 32'd1);
    chk("ar_fwd", {27'd0, fwd_rs_d, fwd_rt_d, fwd_rt_m}, 32'd0);
    #2;
    rst_n = 1'b1;
    step(addu1, 32'h700);
    chk("ar_first_load", instr_d, addu1);
    chk("ar_first_pc", pc_d, 32'h700);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
